// File: rtl/axi4_burst_write_master.sv
// AXI4 write-channel burst master: one command at a time, AW -> W stream -> B,
// with a one-cycle completion strobe. Illegal commands complete locally.
module axi4_burst_write_master #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic                  wr_data_valid,
    output logic                  wr_data_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    output logic [ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [7:0]            M_AXI_AWLEN,
    output logic [2:0]            M_AXI_AWSIZE,
    output logic [1:0]            M_AXI_AWBURST,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    output logic                  M_AXI_WLAST,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic                  rsp_valid,
    output logic [ID_WIDTH-1:0]   rsp_id,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_local,
    output logic                  rsp_id_err,
    output logic                  busy
);

    localparam int unsigned SIZE_MAX  = $clog2(STRB_WIDTH);
    localparam int unsigned CNT_WIDTH = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_RESP,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] loaded;
    logic [CNT_WIDTH-1:0] beats_total;
    logic                 cmd_illegal;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 b_hs;
    logic                 load;

    // Next-state, handshake decode and source back-pressure
    always_comb begin
        state_next    = state;
        cmd_illegal   = 1'b0;
        aw_hs         = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs          = M_AXI_WVALID && M_AXI_WREADY;
        b_hs          = M_AXI_BVALID && M_AXI_BREADY;
        beats_total   = CNT_WIDTH'(M_AXI_AWLEN) + CNT_WIDTH'(1);
        wr_data_ready = 1'b0;
        load          = 1'b0;

        if ((cmd_burst == 2'b11) || (cmd_size > 3'(SIZE_MAX)) ||
            ((cmd_burst == 2'b10) && !((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                                       (cmd_len == 8'd7) || (cmd_len == 8'd15)))) begin
            cmd_illegal = 1'b1;
        end

        // First beat may load on the AW handshake edge; it is presented only after it
        if (((state == S_DATA) || ((state == S_ADDR) && aw_hs)) &&
            (loaded < beats_total) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            wr_data_ready = 1'b1;
        end
        load = wr_data_ready && wr_data_valid;

        case (state)
            S_IDLE: if (cmd_valid) state_next = cmd_illegal ? S_DONE : S_ADDR;
            S_ADDR: if (aw_hs) state_next = S_DATA;
            S_DATA: if (w_hs && M_AXI_WLAST) state_next = S_RESP;
            S_RESP: if (b_hs) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register, registered handshake outputs, W stage and response capture
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            busy          <= 1'b0;
            loaded        <= '0;
            M_AXI_AWID    <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWSIZE  <= '0;
            M_AXI_AWBURST <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_resp      <= '0;
            rsp_local     <= 1'b0;
            rsp_id_err    <= 1'b0;
        end else begin
            state         <= state_next;
            cmd_ready     <= (state_next == S_IDLE);
            busy          <= (state_next != S_IDLE);
            M_AXI_AWVALID <= (state_next == S_ADDR);
            M_AXI_BREADY  <= (state_next == S_RESP);
            rsp_valid     <= (state_next == S_DONE);

            if ((state == S_IDLE) && cmd_valid) begin
                M_AXI_AWID    <= cmd_id;
                M_AXI_AWADDR  <= cmd_addr;
                M_AXI_AWLEN   <= cmd_len;
                M_AXI_AWSIZE  <= cmd_size;
                M_AXI_AWBURST <= cmd_burst;
                loaded        <= '0;
                if (cmd_illegal) begin
                    rsp_id     <= cmd_id;
                    rsp_resp   <= 2'b10;
                    rsp_local  <= 1'b1;
                    rsp_id_err <= 1'b0;
                end
            end

            if (load) begin
                M_AXI_WDATA  <= wr_data;
                M_AXI_WSTRB  <= wr_strb;
                M_AXI_WVALID <= 1'b1;
                M_AXI_WLAST  <= (loaded == CNT_WIDTH'(M_AXI_AWLEN));
                loaded       <= loaded + CNT_WIDTH'(1);
            end else if (w_hs) begin
                M_AXI_WVALID <= 1'b0;
                M_AXI_WLAST  <= 1'b0;
            end

            if ((state == S_RESP) && b_hs) begin
                rsp_id     <= M_AXI_AWID;
                rsp_resp   <= M_AXI_BRESP;
                rsp_local  <= 1'b0;
                rsp_id_err <= (M_AXI_BID != M_AXI_AWID);
            end
        end
    end

endmodule

// File: tb/tb_axi4_burst_write_master.sv
// Scoreboard bench for axi4_burst_write_master: stimulus pushes expected AW/W/rsp
// records, a negedge monitor pops and compares whenever the DUT presents them.
module tb_axi4_burst_write_master;

    localparam int unsigned IW = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } w_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } src_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [1:0]    resp;
        logic          loc;
        logic          id_err;
    } rsp_t;

    logic ACLK = 1'b0;
    logic ARESET;
    logic cmd_valid, cmd_ready;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_size;
    logic [1:0]    cmd_burst;
    logic wr_data_valid, wr_data_ready;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [IW-1:0] M_AXI_AWID;
    logic [AW-1:0] M_AXI_AWADDR;
    logic [7:0]    M_AXI_AWLEN;
    logic [2:0]    M_AXI_AWSIZE;
    logic [1:0]    M_AXI_AWBURST;
    logic          M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0] M_AXI_WDATA;
    logic [SW-1:0] M_AXI_WSTRB;
    logic          M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic [IW-1:0] M_AXI_BID;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID, M_AXI_BREADY;
    logic          rsp_valid;
    logic [IW-1:0] rsp_id;
    logic [1:0]    rsp_resp;
    logic          rsp_local, rsp_id_err, busy;

    axi4_burst_write_master #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_strb(wr_strb),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_local(rsp_local),
        .rsp_id_err(rsp_id_err), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    aw_t  exp_aw_q[$];
    w_t   exp_w_q[$];
    src_t src_q[$];
    b_t   b_plan_q[$];
    rsp_t exp_rsp_q[$];

    int checks = 0;
    int errors = 0;
    int slave_mode = 0;   // 0 always ready, 1 random, 2 alternating WREADY
    int src_mode = 0;     // 0 always valid, 1 random
    int aw_stall = 0;
    int b_owed = 0;
    int w_cnt = 0;
    logic hs_src = 1'b0, hs_b = 1'b0, hs_wlast = 1'b0, wtog = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: observes handshakes that will complete on the coming rising edge
    aw_t  prev_aw;
    w_t   prev_w;
    logic prev_aw_stall = 1'b0, prev_w_stall = 1'b0, aw_done = 1'b0;
    logic prev_rsp = 1'b0, b_pend = 1'b0;
    always @(negedge ACLK) begin
        aw_t  a;
        w_t   w;
        rsp_t r;
        if (ARESET) begin
            hs_src = 1'b0; hs_b = 1'b0; hs_wlast = 1'b0;
            prev_aw_stall = 1'b0; prev_w_stall = 1'b0; aw_done = 1'b0;
            prev_rsp = 1'b0; b_pend = 1'b0;
        end else begin
            w.data = M_AXI_WDATA; w.strb = M_AXI_WSTRB; w.last = M_AXI_WLAST;
            if (prev_w_stall) chk("w_hold", 64'({M_AXI_WVALID, w}), 64'({1'b1, prev_w}));
            if (M_AXI_WVALID) chk("w_after_aw", 64'(aw_done), 64'(1));
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                if (exp_w_q.size() == 0) chk("w_unexpected", 64'(w), 64'(0));
                else chk("w_beat", 64'(w), 64'(exp_w_q.pop_front()));
                w_cnt++;
                if (M_AXI_WLAST) aw_done = 1'b0;
            end
            prev_w_stall = M_AXI_WVALID && !M_AXI_WREADY;
            prev_w = w;

            a.id = M_AXI_AWID; a.addr = M_AXI_AWADDR; a.len = M_AXI_AWLEN;
            a.size = M_AXI_AWSIZE; a.burst = M_AXI_AWBURST;
            if (prev_aw_stall) chk("aw_hold", 64'({M_AXI_AWVALID, a}), 64'({1'b1, prev_aw}));
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                if (exp_aw_q.size() == 0) chk("aw_unexpected", 64'(a), 64'(0));
                else chk("aw_fields", 64'(a), 64'(exp_aw_q.pop_front()));
                aw_done = 1'b1;
            end
            prev_aw_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
            prev_aw = a;

            if (b_pend) chk("b_to_rsp", 64'(rsp_valid), 64'(1));
            if (rsp_valid) begin
                chk("rsp_pulse", 64'(prev_rsp), 64'(0));
                r.id = rsp_id; r.resp = rsp_resp; r.loc = rsp_local; r.id_err = rsp_id_err;
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 64'(r), 64'(0));
                else chk("rsp_fields", 64'(r), 64'(exp_rsp_q.pop_front()));
            end
            prev_rsp = rsp_valid;

            hs_src   = wr_data_valid && wr_data_ready;
            hs_b     = M_AXI_BVALID && M_AXI_BREADY;
            hs_wlast = M_AXI_WVALID && M_AXI_WREADY && M_AXI_WLAST;
            b_pend   = hs_b;
        end
    end

    // Slave model: AWREADY/WREADY patterns and one B response per completed burst
    initial begin
        b_t b;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_BID = '0; M_AXI_BRESP = '0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESET) begin
                M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; b_owed = 0;
            end else begin
                if (aw_stall > 0 && M_AXI_AWVALID) begin
                    M_AXI_AWREADY = 1'b0;
                    aw_stall--;
                end else begin
                    M_AXI_AWREADY = (slave_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                wtog = ~wtog;
                case (slave_mode)
                    0:       M_AXI_WREADY = 1'b1;
                    1:       M_AXI_WREADY = 1'($urandom_range(0, 1));
                    default: M_AXI_WREADY = wtog;
                endcase
                if (hs_wlast) b_owed++;
                if (hs_b) M_AXI_BVALID = 1'b0;
                if (!M_AXI_BVALID && b_owed > 0 && b_plan_q.size() > 0 &&
                    (slave_mode == 0 || $urandom_range(0, 1) == 1)) begin
                    b = b_plan_q.pop_front();
                    M_AXI_BVALID = 1'b1; M_AXI_BID = b.id; M_AXI_BRESP = b.resp;
                    b_owed--;
                end
            end
        end
    end

    // Data source: presents queued beats, holds each until accepted
    initial begin
        src_t s;
        wr_data_valid = 1'b0; wr_data = '0; wr_strb = '0;
        forever begin
            @(posedge ACLK); #1;
            if (ARESET) begin
                wr_data_valid = 1'b0;
            end else begin
                if (hs_src) begin
                    void'(src_q.pop_front());
                    wr_data_valid = 1'b0;
                end
                if (!wr_data_valid && src_q.size() > 0 &&
                    (src_mode == 0 || $urandom_range(0, 1) == 1)) begin
                    s = src_q[0];
                    wr_data_valid = 1'b1; wr_data = s.data; wr_strb = s.strb;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge ACLK); #3; n++;
        end while (!(exp_rsp_q.size() == 0 && cmd_ready) && n < 5000);
        chk("idle_timeout", 64'(n < 5000), 64'(1));
    endtask

    // Reference model: decides legality from the burst rules and queues expectations
    task automatic issue_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [IW-1:0] bid,
                             input logic [1:0] bresp, input bit seq,
                             input logic [DW-1:0] base, input bit wait_done);
        bit   legal;
        int   nbeats;
        int   n;
        aw_t  a;
        src_t s;
        w_t   w;
        b_t   b;
        rsp_t r;
        nbeats = int'(len) + 1;
        legal = (burst != 2'b11) && ((1 << size) <= SW) &&
                !(burst == 2'b10 && !(nbeats == 2 || nbeats == 4 || nbeats == 8 || nbeats == 16));
        r.id = id;
        if (legal) begin
            a.id = id; a.addr = addr; a.len = len; a.size = size; a.burst = burst;
            exp_aw_q.push_back(a);
            for (int i = 0; i < nbeats; i++) begin
                s.data = seq ? base + DW'(i) : DW'($urandom);
                s.strb = SW'($urandom);
                src_q.push_back(s);
                w.data = s.data; w.strb = s.strb; w.last = (i == nbeats - 1);
                exp_w_q.push_back(w);
            end
            b.id = bid; b.resp = bresp;
            b_plan_q.push_back(b);
            r.resp = bresp; r.loc = 1'b0; r.id_err = (bid != id);
        end else begin
            r.resp = 2'b10; r.loc = 1'b1; r.id_err = 1'b0;
        end
        exp_rsp_q.push_back(r);

        @(posedge ACLK); #1;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
        n = 0;
        @(negedge ACLK);
        while (!cmd_ready && n < 2000) begin
            @(negedge ACLK); n++;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'(1));
        @(posedge ACLK); #1;
        cmd_valid = 1'b0;
        @(negedge ACLK);
        if (legal) chk("aw_latency", 64'({rsp_valid, M_AXI_AWVALID}), 64'(2'b01));
        else chk("local_latency", 64'({rsp_valid, M_AXI_AWVALID}), 64'(2'b10));
        if (wait_done) wait_idle();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base_cnt;
        logic [IW-1:0] rid;
        logic [IW-1:0] rbid;
        ARESET = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0;
        cmd_len = '0; cmd_size = '0; cmd_burst = '0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("reset_outputs", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
                                  rsp_valid, busy}), 64'(0));
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge ACLK); #3;
        ARESET = 1'b0;

        // Basic INCR burst, everything ready
        issue_cmd(4'd5, 32'h100, 8'd3, 3'd2, 2'b01, 4'd5, 2'b00, 1, 32'hA0, 1);

        // AWREADY held low for 3 cycles
        aw_stall = 3;
        issue_cmd(4'd2, 32'h200, 8'd1, 3'd2, 2'b01, 4'd2, 2'b00, 0, 0, 1);

        // Alternating WREADY over an 8-beat burst
        slave_mode = 2;
        issue_cmd(4'd3, 32'h300, 8'd7, 3'd2, 2'b01, 4'd3, 2'b01, 1, 32'h0, 1);
        slave_mode = 0;

        // Illegal commands: reserved burst, WRAP len=2, oversize beat
        issue_cmd(4'd7, 32'h0, 8'd1, 3'd2, 2'b11, 4'd0, 2'b00, 0, 0, 1);
        issue_cmd(4'd8, 32'h0, 8'd2, 3'd2, 2'b10, 4'd0, 2'b00, 0, 0, 1);
        issue_cmd(4'd9, 32'h0, 8'd0, 3'd3, 2'b01, 4'd0, 2'b00, 0, 0, 1);

        // Legal WRAP and a mismatched BID with SLVERR
        issue_cmd(4'd4, 32'h40, 8'd3, 3'd2, 2'b10, 4'd4, 2'b00, 0, 0, 1);
        issue_cmd(4'd5, 32'h500, 8'd1, 3'd2, 2'b01, 4'd6, 2'b10, 0, 0, 1);

        // 256-beat burst exercises the full counter range
        issue_cmd(4'd1, 32'h1000, 8'd255, 3'd2, 2'b01, 4'd1, 2'b00, 0, 0, 1);

        // Reset in the middle of a burst
        base_cnt = w_cnt;
        issue_cmd(4'd6, 32'h600, 8'd3, 3'd2, 2'b01, 4'd6, 2'b00, 0, 0, 0);
        n = 0;
        while (w_cnt < base_cnt + 2 && n < 1000) begin
            @(posedge ACLK); #3; n++;
        end
        chk("mid_burst_reach", 64'(n < 1000), 64'(1));
        ARESET = 1'b1;
        @(posedge ACLK); #3;
        exp_aw_q.delete(); exp_w_q.delete(); src_q.delete();
        b_plan_q.delete(); exp_rsp_q.delete();
        @(negedge ACLK);
        chk("abort_outputs", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY,
                                  rsp_valid, busy}), 64'(0));
        @(posedge ACLK); #3;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
        issue_cmd(4'd10, 32'h700, 8'd0, 3'd1, 2'b01, 4'd10, 2'b00, 1, 32'h55, 1);

        // Randomized commands and handshake timing
        for (int k = 0; k < 40; k++) begin
            slave_mode = int'($urandom_range(0, 2));
            src_mode   = int'($urandom_range(0, 1));
            rid  = IW'($urandom);
            rbid = ($urandom_range(0, 3) == 0) ? IW'($urandom) : rid;
            issue_cmd(rid, AW'($urandom),
                      ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                      3'($urandom_range(0, 3)), 2'($urandom), rbid, 2'($urandom), 0, 0, 1);
        end

        chk("aw_q_empty", 64'(exp_aw_q.size()), 64'(0));
        chk("w_q_empty", 64'(exp_w_q.size()), 64'(0));
        chk("rsp_q_empty", 64'(exp_rsp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_burst_write_master.md
Name: axi4_burst_write_master

Overview:
AXI4 write-channel master that drives the AW/W/B channels of the AXI4 slave subsystem. It accepts one burst command at a time from a local command port and streams write beats from a valid/ready data source. It collects the B response and reports it on a one-cycle response strobe. Illegal commands complete locally and generate no bus traffic, so the slave-side protocol checks are never violated by this block.

Parameters:
ID_WIDTH, 4, width of cmd_id / AWID / BID
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width in bits (multiple of 8, max 1024); STRB_WIDTH = DATA_WIDTH/8

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_id  in  ID_WIDTH  burst ID
cmd_addr  in  ADDR_WIDTH  start address
cmd_len  in  8  beats-1
cmd_size  in  3  log2 bytes/beat
cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
wr_data_valid  in  1  source beat valid
wr_data_ready  out  1  source beat accepted
wr_data  in  DATA_WIDTH  beat data
wr_strb  in  STRB_WIDTH  beat strobes
M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  ID_WIDTH/ADDR_WIDTH/8/3/2  registered command fields
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_WDATA/WSTRB  out  DATA_WIDTH/STRB_WIDTH
M_AXI_WLAST  out  1
M_AXI_WVALID  out  1
M_AXI_WREADY  in  1
M_AXI_BID  in  ID_WIDTH
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  ID_WIDTH  ID of completed command
rsp_resp  out  2  BRESP, or 2'b10 for a locally rejected command
rsp_local  out  1  command rejected without bus traffic
rsp_id_err  out  1  BID did not match the issued AWID
busy  out  1  state != IDLE

Behaviour:
- Reset (ARESET=1 at an edge): state=IDLE. All valids, BREADY, WLAST, rsp_* and counters go to 0; AW/W payload registers go to 0. An in-flight burst is abandoned with no response. Reset overrides every other event in the same cycle.
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE: cmd_ready=1.
  - On cmd_valid, latch the command.
  - Illegal command goes to DONE with rsp_resp=2'b10 and rsp_local=1. Illegal means any of: cmd_burst=2'b11; cmd_size > log2(STRB_WIDTH); WRAP with cmd_len not in {1,3,7,15}.
  - Legal command goes to ADDR; AWVALID=1 from the next cycle.
- ADDR: AW fields and AWVALID are held stable until AWVALID&&AWREADY. On that handshake: AWVALID=0, go to DATA. No W beat is ever presented before the AW handshake.
- DATA: W output is a one-entry registered stage.
  - wr_data_ready = (loaded < len+1) && (!WVALID || WREADY).
  - A source handshake loads WDATA/WSTRB, sets WVALID, increments loaded, and sets WLAST=1 iff this is beat len.
  - While WVALID && !WREADY, WDATA/WSTRB/WLAST are held stable.
  - WVALID clears on handshake unless a new beat loads in the same cycle. Back-to-back beats give full throughput.
  - After the handshake of the WLAST beat: WVALID=0, WLAST=0, go to RESP.
  - WSTRB is passed through unmodified.
- RESP: BREADY=1. On BVALID&&BREADY: capture BRESP; set rsp_id_err = (BID != latched id); go to DONE. BVALID seen outside RESP is ignored (BREADY=0).
- DONE: rsp_valid=1 for exactly one cycle with rsp_id = latched id; return to IDLE next cycle. rsp_* fields remain valid until the next rsp_valid.
- Counter loaded is 9 bits, so cmd_len=255 gives 256 beats with no wrap. Both counters are cleared on entering ADDR.
- Latency:
  - cmd accept to AWVALID: 1 cycle.
  - AW handshake to first possible WVALID: 1 cycle.
  - B handshake to rsp_valid: 1 cycle.
  - Illegal cmd accept to rsp_valid: 1 cycle.

Test Plan:
- INCR, id=5, addr=0x100, len=3, size=2; AWREADY, WREADY and BREADY-side slave always ready; source data 0xA0..0xA3 -> single AW handshake with AWLEN=3; 4 W beats in order with WLAST only on 0xA3; BRESP=00, BID=5 -> rsp_valid one cycle, rsp_resp=00, rsp_id=5, rsp_id_err=0.
- AWREADY held low 3 cycles -> AWVALID and AW fields constant for all 4 cycles; WVALID=0 until the cycle after the AW handshake.
- WREADY pattern 0,1,0,1,... with len=7, data 0..7 -> WDATA/WSTRB stable on every stalled cycle; 8 beats delivered in order; WLAST on beat 7 only.
- cmd_burst=2'b11, then WRAP with len=2, then size=3 with DATA_WIDTH=32 -> no AWVALID ever; each command gives rsp_valid 1 cycle after accept with rsp_resp=10 and rsp_local=1.
- Legal INCR id=5, slave returns BID=6 with BRESP=10 -> rsp_resp=10, rsp_id=5, rsp_id_err=1.
- Assert ARESET after 2 of 4 W beats -> next edge all valids=0, BREADY=0, busy=0; after release cmd_ready=1 and a new len=0 burst completes normally with WLAST on its single beat.
